// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped one-word-line instruction cache with single-miss refill FSM
module inst_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        if_hit,
    output logic [31:0] if_inst,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_inst
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [29:0]        miss_word_q, miss_word_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];
    logic               fill_en;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_match;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_W-1:0]      miss_tag;
    logic                  unused_pc_bits;

    assign lk_idx         = if_pc[INDEX_BITS+1:2];
    assign lk_tag         = if_pc[31:INDEX_BITS+2];
    assign miss_idx       = miss_word_q[INDEX_BITS-1:0];
    assign miss_tag       = miss_word_q[29:INDEX_BITS];
    assign unused_pc_bits = ^if_pc[1:0];

    // Lookup: a hit needs a resident matching line, an idle FSM and no flush this cycle
    always_comb begin
        lk_match = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        if_hit   = if_valid && (state_q == IDLE) && lk_match && !clr;
        if_inst  = if_hit ? data_q[lk_idx] : 32'h0;
    end

    // Refill request is a pure function of the registered state and latched address
    always_comb begin
        mc_req  = (state_q == MISS);
        mc_addr = (state_q == MISS) ? {miss_word_q, 2'b00} : 32'h0;
    end

    // Next-state: flush beats a coincident mc_done; rdy low freezes everything
    always_comb begin
        state_d     = state_q;
        miss_word_d = miss_word_q;
        fill_en     = 1'b0;
        if (rdy) begin
            if (clr) begin
                state_d = IDLE;
            end else if (state_q == IDLE) begin
                if (if_valid && !lk_match) begin
                    miss_word_d = if_pc[31:2];
                    state_d     = MISS;
                end
            end else if (mc_done) begin
                fill_en = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // FSM state, latched miss address and valid bits; reset abandons any refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            miss_word_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_word_q <= miss_word_d;
            if (fill_en) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are not reset; they are only meaningful under a set valid bit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[miss_idx] <= mc_inst;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - directed self-checking bench for inst_cache
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_hit;
    logic [31:0] if_inst;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_inst;

    int passed = 0;
    int total  = 0;

    inst_cache #(.INDEX_BITS(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .clr      (clr),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_hit   (if_hit),
        .if_inst  (if_inst),
        .mc_req   (mc_req),
        .mc_addr  (mc_addr),
        .mc_done  (mc_done),
        .mc_inst  (mc_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    // advance past the next rising edge, then let inputs change away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // complete a miss-and-refill for pc, leaving the FSM idle with if_valid low
    task automatic fill(input logic [31:0] pc, input logic [31:0] word);
        if_valid = 1'b1;
        if_pc    = pc;
        tick();
        mc_done = 1'b1;
        mc_inst = word;
        tick();
        mc_done  = 1'b0;
        if_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; clr = 1'b0;
        if_valid = 1'b0; if_pc = 32'h0; mc_done = 1'b0; mc_inst = 32'h0;
        #2;
        check("reset_mc_req",  {31'h0, mc_req}, 32'h0);
        check("reset_mc_addr", mc_addr,         32'h0);
        check("reset_if_hit",  {31'h0, if_hit}, 32'h0);
        check("reset_if_inst", if_inst,         32'h0);
        tick();
        rst = 1'b1;
        tick();

        // cold miss
        if_valid = 1'b1; if_pc = 32'h0000_1004; #1;
        check("cold_same_cycle_hit", {31'h0, if_hit}, 32'h0);
        tick();
        check("cold_mc_req",  {31'h0, mc_req}, 32'h1);
        check("cold_mc_addr", mc_addr,         32'h0000_1004);
        mc_done = 1'b1; mc_inst = 32'h0050_0093;
        tick();
        mc_done = 1'b0; #1;
        check("cold_req_drop", {31'h0, mc_req}, 32'h0);
        check("cold_hit",      {31'h0, if_hit}, 32'h1);
        check("cold_inst",     if_inst,         32'h0050_0093);

        // stray mc_done while idle is ignored
        if_valid = 1'b0; mc_done = 1'b1; mc_inst = 32'hFFFF_FFFF;
        tick();
        mc_done = 1'b0; #1;
        check("idle_done_req", {31'h0, mc_req}, 32'h0);
        if_valid = 1'b1; #1;
        check("idle_done_inst", if_inst, 32'h0050_0093);
        if_valid = 1'b0;

        // conflict eviction at index 4
        fill(32'h0000_0010, 32'h1111_1111);
        if_valid = 1'b1; if_pc = 32'h0000_0010; #1;
        check("pre_evict_inst", if_inst, 32'h1111_1111);
        if_valid = 1'b0;
        fill(32'h0000_0110, 32'hDEAD_BEEF);
        if_valid = 1'b1; if_pc = 32'h0000_0010; #1;
        check("evicted_miss", {31'h0, if_hit}, 32'h0);
        if_pc = 32'h0000_0110; #1;
        check("evictor_hit",  {31'h0, if_hit}, 32'h1);
        check("evictor_inst", if_inst,         32'hDEAD_BEEF);
        if_valid = 1'b0;

        // flush forces a miss on a resident line while asserted
        if_valid = 1'b1; if_pc = 32'h0000_1004; clr = 1'b1; #1;
        check("clr_forces_miss", {31'h0, if_hit}, 32'h0);
        clr = 1'b0; #1;
        check("clr_release_hit", {31'h0, if_hit}, 32'h1);

        // flush during MISS discards the coincident refill
        if_pc = 32'h0000_0020;
        tick();
        check("flush_req_before", {31'h0, mc_req}, 32'h1);
        clr = 1'b1; mc_done = 1'b1; mc_inst = 32'h1234_5678;
        tick();
        clr = 1'b0; mc_done = 1'b0; if_valid = 1'b0; #1;
        check("flush_req_after", {31'h0, mc_req}, 32'h0);
        if_valid = 1'b1; #1;
        check("flush_line_absent", {31'h0, if_hit}, 32'h0);
        if_pc = 32'h0000_1004; #1;
        check("flush_old_line_hit", if_inst, 32'h0050_0093);
        if_valid = 1'b0;

        // rdy stall during MISS ignores mc_done
        if_valid = 1'b1; if_pc = 32'h0000_0030;
        tick();
        rdy = 1'b0; mc_done = 1'b1; mc_inst = 32'hCAFE_F00D;
        tick();
        check("stall_req",  {31'h0, mc_req}, 32'h1);
        check("stall_addr", mc_addr,         32'h0000_0030);
        rdy = 1'b1; mc_done = 1'b0;
        tick();
        check("stall_still_miss", {31'h0, mc_req}, 32'h1);
        mc_done = 1'b1; mc_inst = 32'hA5A5_A5A5;
        tick();
        mc_done = 1'b0; #1;
        check("stall_fill_hit",  {31'h0, if_hit}, 32'h1);
        check("stall_fill_inst", if_inst,         32'hA5A5_A5A5);
        if_valid = 1'b0;

        // pc change during MISS: refill goes to the latched address
        if_valid = 1'b1; if_pc = 32'h0000_0040;
        tick();
        if_pc = 32'h0000_0080;
        tick();
        check("addrchg_latched", mc_addr, 32'h0000_0040);
        mc_done = 1'b1; mc_inst = 32'h4040_4040;
        tick();
        mc_done = 1'b0; #1;
        check("addrchg_new_miss", {31'h0, if_hit}, 32'h0);
        tick();
        check("addrchg_new_addr", mc_addr, 32'h0000_0080);
        mc_done = 1'b1; mc_inst = 32'h8080_8080;
        tick();
        mc_done = 1'b0; #1;
        check("addrchg_80_inst", if_inst, 32'h8080_8080);
        if_pc = 32'h0000_0040; #1;
        check("addrchg_40_inst", if_inst, 32'h4040_4040);
        if_valid = 1'b0;

        // asynchronous reset mid-MISS
        if_valid = 1'b1; if_pc = 32'h0000_0050;
        tick();
        check("arst_req_before", {31'h0, mc_req}, 32'h1);
        if_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_req_now",  {31'h0, mc_req}, 32'h0);
        check("arst_addr_now", mc_addr,         32'h0);
        #1 rst = 1'b1;
        tick();
        if_valid = 1'b1; if_pc = 32'h0000_1004; #1;
        check("arst_1004_miss", {31'h0, if_hit}, 32'h0);
        if_pc = 32'h0000_0110; #1;
        check("arst_0110_miss", {31'h0, if_hit}, 32'h0);
        if_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
